hdmi_pll_ctrl: RTL and testbench

Power-up and lock supervisor for the HDMI clock PLL, running on the 50 MHz `refclk`. It drives the PLL `reset` pin through a timed reset pulse, waits for `extlock` with a timeout and retry, and qualifies lock over a stability window. It then releases the video-domain reset request and `ready`. On lock loss it tears down and restarts. It sits between the board reset and the HDMI PLL / TMDS encoder reset tree.

---
 rtl/hdmi_pll_ctrl_pkg.sv | 33 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/hdmi_pll_ctrl.sv | 173 +++++++++++++++++
 tb/tb_hdmi_pll_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pll_ctrl_pkg.sv
// Shared types and constants for the HDMI PLL power-up / lock supervisor.
// Holds the FSM state encoding, default parameter values and the counter-width helper.
package hdmi_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int unsigned DEF_RST_CYCLES    = 32;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_MAX_RETRY     = 4;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned RETRY_W = 4;
    localparam int unsigned LOSS_W  = 8;

    // Counter only needs to reach (largest period - 1), so clog2 of the largest period is enough.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with synchronous active-high reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hdmi_pll_ctrl.sv
// HDMI PLL reset/lock supervisor: timed PLL reset, lock wait with timeout/retry,
// lock qualification window, and teardown on lock loss. Macro: HDMI_PLL_CTRL_RETRY_LIMIT_EN.
module hdmi_pll_ctrl
    import hdmi_pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                refclk,
    input  logic                reset,
    input  logic                extlock,
    input  logic                soft_reset,
    output logic                pll_reset,
    output logic                video_rst,
    output logic                ready,
    output logic                fail,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [LOSS_W-1:0]   loss_cnt,
    output logic [STATE_W-1:0]  state
);

    localparam int unsigned CNT_W    = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int unsigned RETRY_NW = RETRY_W + 1;

    localparam logic [CNT_W-1:0]    HOLD_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_NW-1:0] RETRY_LIMIT = RETRY_NW'(MAX_RETRY);

`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [LOSS_W-1:0]    loss_q, loss_d;
    logic                 lock_s;
    logic                 pll_reset_d, video_rst_d, ready_d;
    logic [RETRY_W-1:0]   retry_inc;
    logic                 retry_hit;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk   (refclk),
        .reset (reset),
        .d     (extlock),
        .q     (lock_s)
    );

    // Saturating retry increment and "this timeout exhausts the budget" flag.
    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;
    assign retry_hit = (({1'b0, retry_q} + RETRY_NW'(1)) == RETRY_LIMIT);

    // State register; all outputs are registered alongside the state.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_reset <= 1'b1;
            video_rst <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_reset <= pll_reset_d;
            video_rst <= video_rst_d;
            ready     <= ready_d;
        end
    end

    // Next-state, phase counter and statistics.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock beats a coincident timeout.
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == WAIT_LAST) begin
                    retry_d = retry_inc;
                    state_d = (RETRY_EN && retry_hit) ? ST_FAIL : ST_HOLD;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_HOLD;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Soft restart overrides every transition above but keeps the loss statistic.
        if (soft_reset) begin
            state_d = ST_HOLD;
            retry_d = '0;
            loss_d  = loss_q;
        end

        if (soft_reset || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((state_q == ST_HOLD) || (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output decode from the next state so outputs change on the same edge as state.
    always_comb begin
        pll_reset_d = 1'b0;
        video_rst_d = 1'b1;
        ready_d     = 1'b0;
        case (state_d)
            ST_HOLD:      pll_reset_d = 1'b1;
            ST_WAIT_LOCK: pll_reset_d = 1'b0;
            ST_STABLE:    pll_reset_d = 1'b0;
            ST_RUN: begin
                video_rst_d = 1'b0;
                ready_d     = 1'b1;
            end
            ST_FAIL:      pll_reset_d = 1'b1;
            default:      pll_reset_d = 1'b1;
        endcase
    end

`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
    logic fail_d;

    // Sticky while in FAIL; only reset or soft_reset move the FSM out.
    assign fail_d = (state_d == ST_FAIL);

    always_ff @(posedge refclk) begin
        if (reset) fail <= 1'b0;
        else       fail <= fail_d;
    end
`else
    assign fail = 1'b0;
`endif

    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_hdmi_pll_ctrl.sv
// Self-checking bench for hdmi_pll_ctrl: directed scenarios plus random extlock
// traffic, all compared against a phase/age reference model.
module tb_hdmi_pll_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 3;

`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       reset = 1'b1;
    logic       extlock = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_reset, video_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int tests_run = 0;
    int tests_failed = 0;

    hdmi_pll_ctrl #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .refclk     (refclk),
        .reset      (reset),
        .extlock    (extlock),
        .soft_reset (soft_reset),
        .pll_reset  (pll_reset),
        .video_rst  (video_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state      (state)
    );

    always #10 refclk = ~refclk;

    // Reference model: phase (spec encoding), cycles spent in phase, stats, extlock history.
    typedef struct {
        int   phase;
        int   age;
        int   retry;
        int   loss;
        logic x1;
        logic x2;
    } mdl_t;

    mdl_t m = '{phase: 0, age: 0, retry: 0, loss: 0, x1: 1'b0, x2: 1'b0};

    function automatic mdl_t mdl_next(input mdl_t c, input logic rst, input logic sr, input logic xl);
        mdl_t n;
        logic seen;
        n = c;
        if (rst) begin
            n = '{phase: 0, age: 0, retry: 0, loss: 0, x1: 1'b0, x2: 1'b0};
        end else begin
            seen = c.x2;          // extlock as it was two edges ago
            n.x2 = c.x1;
            n.x1 = xl;
            if (sr) begin
                n.phase = 0; n.age = 0; n.retry = 0;
            end else begin
                n.age = c.age + 1;
                case (c.phase)
                    0: if (n.age >= RST_CYCLES) begin n.phase = 1; n.age = 0; end
                    1: begin
                        if (seen) begin
                            n.phase = 2; n.age = 0;
                        end else if (n.age >= LOCK_TIMEOUT) begin
                            n.age   = 0;
                            n.retry = (c.retry < 15) ? c.retry + 1 : 15;
                            n.phase = (RETRY_EN && n.retry == MAX_RETRY) ? 4 : 0;
                        end
                    end
                    2: begin
                        if (!seen) begin
                            n.phase = 1; n.age = 0;
                        end else if (n.age >= STABLE_CYCLES) begin
                            n.phase = 3; n.age = 0; n.retry = 0;
                        end
                    end
                    3: begin
                        n.age = 0;
                        if (!seen) begin
                            n.phase = 0;
                            n.loss  = (c.loss < 255) ? c.loss + 1 : 255;
                        end
                    end
                    default: n.age = 0;
                endcase
            end
        end
        return n;
    endfunction

    always @(posedge refclk) m <= mdl_next(m, reset, soft_reset, extlock);

    function automatic logic [18:0] model_vec();
        logic pr, vr, rd, fl;
        pr = (m.phase == 0) || (m.phase == 4);
        vr = (m.phase != 3);
        rd = (m.phase == 3);
        fl = (m.phase == 4);
        return {3'(m.phase), pr, vr, rd, fl, 4'(m.retry), 8'(m.loss)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {state, pll_reset, video_rst, ready, fail, retry_cnt, loss_cnt};
    endfunction

    task automatic do_reset();
        @(negedge refclk);
        reset = 1'b1; soft_reset = 1'b0; extlock = 1'b0;
        repeat (2) @(negedge refclk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge refclk);
        tests_run++;
        if (dut_vec() !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL reset_values got=%h want=%h", dut_vec(), {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
        end
        reset = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (pll_reset !== 1'(cyc < RST_CYCLES)) begin
                tests_failed++;
                $display("FAIL reset_pulse cyc=%0d pll_reset=%b want=%b", cyc, pll_reset, cyc < RST_CYCLES);
            end
        end
    endtask

    task automatic test_bringup();
        int first_low, first_rdy;
        first_low = -1; first_rdy = -1;
        do_reset();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL bringup_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (pll_reset === 1'b0 && first_low < 0) first_low = cyc;
            if (ready === 1'b1 && first_rdy < 0) first_rdy = cyc;
            if (cyc == 10) extlock = 1'b1;
        end
        tests_run++;
        if (first_low != 4) begin
            tests_failed++;
            $display("FAIL bringup_pll_low got=%0d want=4", first_low);
        end
        tests_run++;
        if (first_rdy != 21) begin
            tests_failed++;
            $display("FAIL bringup_ready got=%0d want=21", first_rdy);
        end
        tests_run++;
        if (retry_cnt !== 4'd0) begin
            tests_failed++;
            $display("FAIL bringup_retry got=%0d want=0", retry_cnt);
        end
    endtask

    task automatic test_timeout_retry();
        int hold_len;
        hold_len = 0;
        do_reset();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL retry_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (cyc >= 5 && cyc <= 30 && pll_reset === 1'b1) hold_len++;
            if (cyc == 20) begin
                tests_run++;
                if (state !== 3'd0 || retry_cnt !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL retry_timeout state=%0d retry=%0d want 0/1", state, retry_cnt);
                end
            end
            if (cyc == 36) begin
                tests_run++;
                if (state !== 3'd3 || retry_cnt !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL retry_run state=%0d retry=%0d want 3/0", state, retry_cnt);
                end
            end
            if (cyc == 25) extlock = 1'b1;
        end
        tests_run++;
        if (hold_len != RST_CYCLES) begin
            tests_failed++;
            $display("FAIL retry_hold_len got=%0d want=%0d", hold_len, RST_CYCLES);
        end
    endtask

    task automatic test_retry_limit();
        do_reset();
`ifdef HDMI_PLL_CTRL_RETRY_LIMIT_EN
        for (int cyc = 1; cyc <= 75; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL limit_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (cyc == 60 || cyc == 69) begin
                tests_run++;
                if (state !== 3'd4 || fail !== 1'b1 || pll_reset !== 1'b1 || retry_cnt !== 4'd3) begin
                    tests_failed++;
                    $display("FAIL limit_fail cyc=%0d state=%0d fail=%b pll=%b retry=%0d want 4/1/1/3",
                             cyc, state, fail, pll_reset, retry_cnt);
                end
            end
            if (cyc == 71) begin
                soft_reset = 1'b0;
                tests_run++;
                if (state !== 3'd0 || fail !== 1'b0 || retry_cnt !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL limit_soft state=%0d fail=%b retry=%0d want 0/0/0", state, fail, retry_cnt);
                end
            end
            if (cyc == 70) soft_reset = 1'b1;
        end
`else
        for (int cyc = 1; cyc <= 340; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL limit_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (cyc == 320 || cyc == 340) begin
                tests_run++;
                if (retry_cnt !== 4'd15 || fail !== 1'b0 || state === 3'd4) begin
                    tests_failed++;
                    $display("FAIL limit_saturate cyc=%0d retry=%0d fail=%b state=%0d want 15/0/not4",
                             cyc, retry_cnt, fail, state);
                end
            end
        end
`endif
    endtask

    task automatic test_glitch();
        do_reset();
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL glitch_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (cyc == 19) begin
                tests_run++;
                if (state !== 3'd1 || retry_cnt !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL glitch_drop state=%0d retry=%0d want 1/0", state, retry_cnt);
                end
            end
            if (cyc == 27 || cyc == 28) begin
                tests_run++;
                if (state !== ((cyc == 27) ? 3'd2 : 3'd3)) begin
                    tests_failed++;
                    $display("FAIL glitch_requal cyc=%0d state=%0d want=%0d", cyc, state, (cyc == 27) ? 2 : 3);
                end
            end
            if (cyc == 10) extlock = 1'b1;
            if (cyc == 16) extlock = 1'b0;
            if (cyc == 17) extlock = 1'b1;
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL loss_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (cyc == 27) begin
                tests_run++;
                if (ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL loss_early ready=%b want=1", ready);
                end
            end
            if (cyc == 28) begin
                tests_run++;
                if (ready !== 1'b0 || video_rst !== 1'b1 || pll_reset !== 1'b1 || loss_cnt !== 8'd1) begin
                    tests_failed++;
                    $display("FAIL loss_teardown ready=%b vrst=%b pll=%b loss=%0d want 0/1/1/1",
                             ready, video_rst, pll_reset, loss_cnt);
                end
            end
            if (cyc == 41) begin
                tests_run++;
                if (state !== 3'd3 || loss_cnt !== 8'd1) begin
                    tests_failed++;
                    $display("FAIL loss_relock state=%0d loss=%0d want 3/1", state, loss_cnt);
                end
            end
            if (cyc == 10) extlock = 1'b1;
            if (cyc == 25) extlock = 1'b0;
            if (cyc == 30) extlock = 1'b1;
        end
    endtask

    task automatic test_soft_timeout();
        do_reset();
        for (int cyc = 1; cyc <= 41; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL softto_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (cyc == 20) begin
                soft_reset = 1'b0;
                tests_run++;
                if (state !== 3'd0 || retry_cnt !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL softto_hold state=%0d retry=%0d want 0/0", state, retry_cnt);
                end
            end
            if (cyc == 40) begin
                tests_run++;
                if (retry_cnt !== 4'd1) begin
                    tests_failed++;
                    $display("FAIL softto_next retry=%0d want=1", retry_cnt);
                end
            end
            if (cyc == 19) soft_reset = 1'b1;
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int cyc = 1; cyc <= 27; cyc++) begin
            @(negedge refclk);
            if (cyc == 26) begin
                soft_reset = 1'b0;
                tests_run++;
                if (state !== 3'd0 || loss_cnt !== 8'd1) begin
                    tests_failed++;
                    $display("FAIL midop_soft_keep state=%0d loss=%0d want 0/1", state, loss_cnt);
                end
            end
            if (cyc == 27) begin
                reset = 1'b0;
                tests_run++;
                if (dut_vec() !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}) begin
                    tests_failed++;
                    $display("FAIL midop_reset got=%h want=%h", dut_vec(), {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0});
                end
            end
            if (cyc == 10) extlock = 1'b1;
            if (cyc == 22) extlock = 1'b0;
            if (cyc == 25) soft_reset = 1'b1;
            if (cyc == 26) reset = 1'b1;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 1; cyc <= 900; cyc++) begin
            @(negedge refclk);
            tests_run++;
            if (dut_vec() !== model_vec()) begin
                tests_failed++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec());
            end
            if (extlock ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 11) == 0)) extlock = ~extlock;
            soft_reset = ($urandom_range(0, 199) == 0);
            reset      = ($urandom_range(0, 399) == 0);
        end
        @(negedge refclk);
        reset = 1'b0; soft_reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_timeout_retry();
        test_retry_limit();
        test_glitch();
        test_lock_loss();
        test_soft_timeout();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
